// File: rtl/dmem_port_arbiter.sv
// Two-master front end for the single-port data memory. cpu and nic share one dmem port,
// and read data returns to the granted master one cycle after acceptance.
module dmem_port_arbiter #(
  parameter int CPU_PRIORITY = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_wr,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_data,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  input  logic              nic_req_valid,
  output logic              nic_req_ready,
  input  logic              nic_req_wr,
  input  logic [ADDR_W-1:0] nic_req_addr,
  input  logic [DATA_W-1:0] nic_req_data,
  output logic              nic_rsp_valid,
  output logic [DATA_W-1:0] nic_rsp_data,
  output logic              memEn,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] satInc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  logic       rrLastNic;
  logic [3:0] starveCnt;
  logic       grantCpu_p0;
  logic       grantNic_p0;
  logic       vldCpu_p1;
  logic       vldNic_p1;

  // Stage p0: combinational grant and dmem drive; everything is held off while in reset
  always_comb begin
    grantCpu_p0 = 1'b0;
    grantNic_p0 = 1'b0;
    if (reset_n) begin
      if (cpu_req_valid && nic_req_valid) begin
        if (CPU_PRIORITY != 0) grantNic_p0 = (starveCnt == LIMIT);
        else                   grantNic_p0 = !rrLastNic;
        grantCpu_p0 = !grantNic_p0;
      end else begin
        grantCpu_p0 = cpu_req_valid;
        grantNic_p0 = nic_req_valid;
      end
    end
  end

  assign cpu_req_ready = grantCpu_p0;
  assign nic_req_ready = grantNic_p0;

  always_comb begin
    memEn   = 1'b0;
    memWrEn = 1'b0;
    memAddr = '0;
    dataIn  = '0;
    if (grantCpu_p0) begin
      memEn   = 1'b1;
      memWrEn = cpu_req_wr;
      memAddr = cpu_req_addr;
      dataIn  = cpu_req_data;
    end else if (grantNic_p0) begin
      memEn   = 1'b1;
      memWrEn = nic_req_wr;
      memAddr = nic_req_addr;
      dataIn  = nic_req_data;
    end
  end

  // Stage p1: arbitration history and pending read responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrLastNic <= 1'b1;
      starveCnt <= '0;
      vldCpu_p1 <= 1'b0;
      vldNic_p1 <= 1'b0;
    end else begin
      if (grantCpu_p0 || grantNic_p0) rrLastNic <= grantNic_p0;
      if (!nic_req_valid || grantNic_p0) starveCnt <= '0;
      else                               starveCnt <= satInc(starveCnt);
      vldCpu_p1 <= grantCpu_p0 && !cpu_req_wr;
      vldNic_p1 <= grantNic_p0 && !nic_req_wr;
    end
  end

  // dmem presents read data in the cycle after the accepting edge
  assign cpu_rsp_valid = vldCpu_p1;
  assign nic_rsp_valid = vldNic_p1;
  assign cpu_rsp_data  = vldCpu_p1 ? dataOut : '0;
  assign nic_rsp_data  = vldNic_p1 ? dataOut : '0;

endmodule
